// File: rtl/core_params.sv
// Shared constants for the transmit/receive sample paths: default widths, carrier shape,
// modulator FSM states and the modulator pipeline latency.
package core_params;

   localparam int DEF_DATA_WIDTH      = 8;
   localparam int DEF_WAVELENGTH      = 16;
   localparam int DEF_AMPLITUDE       = 127;
   localparam int DEF_SINE_RESOLUTION = 64;
   localparam int MOD_LATENCY         = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      SYMBOL   = 2'd2
   } mod_state_t;

   // sin(i * pi/32) for i = 0..16 in Q20: one quarter wave of a 64-point period
   function automatic int quarter_sine_q20(input int idx);
      case (idx)
         0:       return 0;
         1:       return 102779;
         2:       return 204567;
         3:       return 304385;
         4:       return 401273;
         5:       return 494295;
         6:       return 582558;
         7:       return 665210;
         8:       return 741455;
         9:       return 810560;
         10:      return 871859;
         11:      return 924762;
         12:      return 968758;
         13:      return 1003425;
         14:      return 1028428;
         15:      return 1043527;
         default: return 1048576;
      endcase
   endfunction

endpackage

// File: rtl/modulator_bit_fifo.sv
// 1-bit synchronous FIFO, FIFO_DEPTH entries (power of 2), active-low synchronous reset.
// A push while full is dropped even if a pop happens on the same edge.
module modulator_bit_fifo #(
   parameter int  FIFO_DEPTH = 8,
   localparam int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic full,
   output logic empty
);
   logic          mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wave_table_sine.sv
// Unsigned sine carrier ROM, one period of WAVELENGTH samples centred on AMPLITUDE,
// with a registered read (one cycle from phase_index to sample).
module wave_table_sine #(
   parameter int DATA_WIDTH      = core_params::DEF_DATA_WIDTH,
   parameter int WAVELENGTH      = core_params::DEF_WAVELENGTH,
   parameter int AMPLITUDE       = core_params::DEF_AMPLITUDE,
   parameter int SINE_RESOLUTION = core_params::DEF_SINE_RESOLUTION,
   localparam int IW             = $clog2(WAVELENGTH)
) (
   input  logic                  clk,
   input  logic [IW-1:0]         phase_index,
   output logic [DATA_WIDTH-1:0] sample
);
   import core_params::*;

   localparam int     QUARTER    = SINE_RESOLUTION / 4;
   localparam longint SAMPLE_MAX = (longint'(1) << DATA_WIDTH) - 1;

   // Peak of 2*AMPLITUDE may exceed the sample width; it saturates to full scale.
   function automatic logic [DATA_WIDTH-1:0] sine_sample(input int p);
      int     k, quad, r, qi;
      longint mag, val;
      k    = p * (SINE_RESOLUTION / WAVELENGTH);
      quad = k / QUARTER;
      r    = k % QUARTER;
      qi   = ((quad % 2) == 1) ? (QUARTER - r) : r;
      qi   = qi * 16 / QUARTER;
      mag  = (longint'(AMPLITUDE) * longint'(quarter_sine_q20(qi)) + 64'sd524288) >>> 20;
      val  = (quad >= 2) ? longint'(AMPLITUDE) - mag : longint'(AMPLITUDE) + mag;
      if (val > SAMPLE_MAX) val = SAMPLE_MAX;
      return DATA_WIDTH'(val);
   endfunction

   logic [DATA_WIDTH-1:0] rom [WAVELENGTH];

   generate
      for (genvar gi = 0; gi < WAVELENGTH; gi++) begin : g_rom
         assign rom[gi] = sine_sample(gi);
      end
   endgenerate

   always_ff @(posedge clk) begin
      sample <= rom[phase_index];
   end

endmodule

// File: rtl/signal_modulator.sv
// BPSK transmit modulator: one carrier period per queued bit, inverted for 0, midscale when idle.
// Define MOD_PREAMBLE_EN to prefix each burst with PREAMBLE_LEN alternating 1,0,... symbols.
module signal_modulator #(
   parameter int DATA_WIDTH   = core_params::DEF_DATA_WIDTH,
   parameter int WAVELENGTH   = core_params::DEF_WAVELENGTH,
   parameter int AMPLITUDE    = core_params::DEF_AMPLITUDE,
   parameter int FIFO_DEPTH   = 8,
   parameter int PREAMBLE_LEN = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bit_in,
   input  logic                  bit_valid,
   output logic                  bit_ready,
   output logic [DATA_WIDTH-1:0] signal,
   output logic                  symbol_start,
   output logic                  busy
);
   import core_params::*;

   localparam int                    PW         = $clog2(WAVELENGTH);
   localparam int                    CW         = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
   localparam logic [PW-1:0]         LAST_PHASE = PW'(WAVELENGTH - 1);
   localparam logic [CW-1:0]         LAST_PRE   = CW'(PREAMBLE_LEN - 1);
   localparam logic [DATA_WIDTH:0]   PEAK       = (DATA_WIDTH+1)'(2 * AMPLITUDE);
   localparam logic [DATA_WIDTH-1:0] MIDSCALE   = DATA_WIDTH'(AMPLITUDE);

   mod_state_t            state;
   logic [PW-1:0]         phase;
   logic [CW-1:0]         pre_cnt;
   logic                  cur_bit;
   logic                  first;
   logic                  last_phase;
   logic                  active;
   logic                  pop;
   logic                  fifo_dout;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [MOD_LATENCY-1:0] valid_pipe;
   logic                  bit_d1;
   logic                  first_d1;
   logic [DATA_WIDTH-1:0] table_sample;
   logic [DATA_WIDTH:0]   inverted;

   modulator_bit_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bit_valid),
      .din   (bit_in),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   wave_table_sine #(
      .DATA_WIDTH (DATA_WIDTH),
      .WAVELENGTH (WAVELENGTH),
      .AMPLITUDE  (AMPLITUDE)
   ) u_table (
      .clk         (clk),
      .phase_index (phase),
      .sample      (table_sample)
   );

   assign bit_ready  = !fifo_full;
   assign last_phase = (phase == LAST_PHASE);
   assign active     = (state != IDLE);
   assign busy       = !fifo_empty || active || (|valid_pipe);

   always_comb begin
      pop = 1'b0;
      case (state)
`ifdef MOD_PREAMBLE_EN
         IDLE:     pop = 1'b0;
`else
         IDLE:     pop = !fifo_empty;
`endif
         PREAMBLE: pop = last_phase && (pre_cnt == LAST_PRE);
         SYMBOL:   pop = last_phase && !fifo_empty;
         default:  pop = 1'b0;
      endcase
   end

   // first marks phase 0 of every symbol; it travels with the phase into the pipeline
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         phase   <= '0;
         pre_cnt <= '0;
         cur_bit <= 1'b0;
         first   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               phase   <= '0;
               pre_cnt <= '0;
               first   <= !fifo_empty;
               if (!fifo_empty) begin
`ifdef MOD_PREAMBLE_EN
                  state   <= PREAMBLE;
                  cur_bit <= 1'b1;
`else
                  state   <= SYMBOL;
                  cur_bit <= fifo_dout;
`endif
               end
            end
            PREAMBLE: begin
               phase <= phase + 1'b1;
               first <= last_phase;
               if (last_phase) begin
                  if (pre_cnt == LAST_PRE) begin
                     state   <= SYMBOL;
                     cur_bit <= fifo_dout;
                     pre_cnt <= '0;
                  end else begin
                     pre_cnt <= pre_cnt + 1'b1;
                     cur_bit <= !cur_bit;
                  end
               end
            end
            SYMBOL: begin
               phase <= phase + 1'b1;
               first <= last_phase && !fifo_empty;
               if (last_phase) begin
                  if (!fifo_empty) cur_bit <= fifo_dout;
                  else             state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bit-0 samples mirror around the offset; the sum can exceed full scale and saturates.
   assign inverted = PEAK - {1'b0, table_sample};

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_pipe   <= '0;
         bit_d1       <= 1'b0;
         first_d1     <= 1'b0;
         signal       <= MIDSCALE;
         symbol_start <= 1'b0;
      end else begin
         valid_pipe <= {valid_pipe[MOD_LATENCY-2:0], active};
         bit_d1     <= cur_bit;
         first_d1   <= first;
         if (valid_pipe[0]) begin
            symbol_start <= first_d1;
            if (bit_d1)
               signal <= table_sample;
            else
               signal <= inverted[DATA_WIDTH] ? '1 : inverted[DATA_WIDTH-1:0];
         end else begin
            symbol_start <= 1'b0;
            signal       <= MIDSCALE;
         end
      end
   end

endmodule

// File: tb/tb_signal_modulator.sv
// Self-checking bench for signal_modulator: randomized bursts compared against a
// sine/BPSK reference model, plus reset, back-pressure and saturation cases.
module tb_signal_modulator;

   localparam int  WL    = 16;
   localparam int  DEPTH = 8;
   localparam real PI    = 3.14159265358979;
`ifdef MOD_PREAMBLE_EN
   localparam int  PRE   = 8;
`else
   localparam int  PRE   = 0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       bit_in0, bit_valid0, ready0, start0, busy0;
   logic       bit_in1, bit_valid1, ready1, start1, busy1;
   logic [7:0] sig0, sig1;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   logic tx_bits [32];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   signal_modulator dut (
      .clk(clk), .reset(reset_n), .bit_in(bit_in0), .bit_valid(bit_valid0),
      .bit_ready(ready0), .signal(sig0), .symbol_start(start0), .busy(busy0)
   );

   signal_modulator #(.AMPLITUDE(128)) dut_a128 (
      .clk(clk), .reset(reset_n), .bit_in(bit_in1), .bit_valid(bit_valid1),
      .bit_ready(ready1), .signal(sig1), .symbol_start(start1), .busy(busy1)
   );

   // Reference: offset sine rounded to nearest, saturated to 8 bits, mirrored for bit 0.
   function automatic int exp_sample(input int amp, input logic b, input int p);
      real v;
      int  mag, t, r;
      v   = real'(amp) * $sin(2.0 * PI * real'(p) / real'(WL));
      mag = $rtoi(((v < 0.0) ? -v : v) + 0.5);
      t   = (v >= 0.0) ? amp + mag : amp - mag;
      if (t > 255) t = 255;
      r = b ? t : 2 * amp - t;
      if (r > 255) r = 255;
      return r;
   endfunction

   function automatic logic [7:0] sig_of(input int sel);   return sel ? sig1 : sig0;     endfunction
   function automatic logic       start_of(input int sel); return sel ? start1 : start0; endfunction
   function automatic logic       busy_of(input int sel);  return sel ? busy1 : busy0;   endfunction
   function automatic logic       ready_of(input int sel); return sel ? ready1 : ready0; endfunction

   task automatic drive(input int sel, input logic b, input logic v);
      if (sel == 0) begin bit_in0 = b; bit_valid0 = v; end
      else          begin bit_in1 = b; bit_valid1 = v; end
   endtask

   // Pushes tx_bits[0..nbits-1] into an idle DUT and checks every output cycle.
   task automatic run_burst(input string name, input int sel, input int nbits, input int amp);
      int c0, stalls, exp_stalls, cnt, rem, pops, p0;
      stalls = 0;
      @(negedge clk);
      c0 = cyc;
      fork
         begin
            int g;
            for (int i = 0; i < nbits; i++) begin
               drive(sel, tx_bits[i], 1'b1);
               g = 0;
               while (!ready_of(sel) && g < 400) begin
                  @(negedge clk);
                  g++;
                  stalls++;
               end
               if (g >= 400) begin
                  errors++;
                  $display("FAIL %s push_timeout bit %0d: ready stayed %b, required 1", name, i, ready_of(sel));
               end
               @(negedge clk);
            end
            drive(sel, 1'b0, 1'b0);
         end
         begin
            int n, sym, p, e_sig;
            logic eb, e_start, e_busy;
            for (int k = 1; k <= 3 + WL * (PRE + nbits) + 3; k++) begin
               @(negedge clk);
               n = k - 4;
               eb = 1'b0;
               if (n >= 0 && n < WL * (PRE + nbits)) begin
                  sym = n / WL;
                  p   = n % WL;
                  eb  = (sym < PRE) ? (sym % 2 == 0) : tx_bits[sym - PRE];
                  e_sig   = exp_sample(amp, eb, p);
                  e_start = (p == 0);
                  e_busy  = 1'b1;
               end else begin
                  e_sig   = amp;
                  e_start = 1'b0;
                  e_busy  = (n < 0);
               end
               checks += 3;
               if (sig_of(sel) !== 8'(e_sig)) begin
                  errors++;
                  $display("FAIL %s signal n=%0d: got %0d, required %0d", name, n, sig_of(sel), e_sig);
               end
               if (start_of(sel) !== e_start) begin
                  errors++;
                  $display("FAIL %s symbol_start n=%0d: got %b, required %b", name, n, start_of(sel), e_start);
               end
               if (busy_of(sel) !== e_busy) begin
                  errors++;
                  $display("FAIL %s busy n=%0d: got %b, required %b", name, n, busy_of(sel), e_busy);
               end
            end
         end
      join
      // Occupancy model: one push per edge unless full, pops at each symbol boundary.
      cnt = 0; rem = nbits; pops = 0; exp_stalls = 0;
      p0 = 2 + WL * PRE;
      for (int t = 1; rem > 0 && t < 2000; t++) begin
         if (cnt == DEPTH) exp_stalls++;
         else begin cnt++; rem--; end
         if (t >= p0 && (t - p0) % WL == 0 && pops < nbits) begin cnt--; pops++; end
      end
      checks++;
      if (stalls != exp_stalls) begin
         errors++;
         $display("FAIL %s ready_stalls: got %0d, required %0d", name, stalls, exp_stalls);
      end
      $display("burst %s: dut%0d, %0d bits, %0d stall cycles", name, sel, nbits, stalls);
   endtask

   task automatic check_idle(input string name, input int sel, input int amp);
      checks += 4;
      if (sig_of(sel) !== 8'(amp)) begin
         errors++; $display("FAIL %s signal: got %0d, required %0d", name, sig_of(sel), amp);
      end
      if (busy_of(sel) !== 1'b0) begin
         errors++; $display("FAIL %s busy: got %b, required 0", name, busy_of(sel));
      end
      if (ready_of(sel) !== 1'b1) begin
         errors++; $display("FAIL %s bit_ready: got %b, required 1", name, ready_of(sel));
      end
      if (start_of(sel) !== 1'b0) begin
         errors++; $display("FAIL %s symbol_start: got %b, required 0", name, start_of(sel));
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle("reset_held", 0, 127);
         check_idle("reset_held_a128", 1, 128);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle("reset_released", 0, 127);
      end
      $display("test_reset: done");
   endtask

   task automatic test_single();
      tx_bits[0] = 1'b1;
      run_burst("single_1", 0, 1, 127);
      tx_bits[0] = 1'b0;
      run_burst("single_0", 0, 1, 127);
   endtask

   task automatic test_pattern();
      tx_bits[0] = 1'b1; tx_bits[1] = 1'b0; tx_bits[2] = 1'b1; tx_bits[3] = 1'b1;
      run_burst("pattern_1011", 0, 4, 127);
   endtask

   task automatic test_random();
      int len;
      for (int r = 0; r < 3; r++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) tx_bits[i] = 1'($urandom_range(0, 1));
         run_burst($sformatf("random_%0d", r), 0, len, 127);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) tx_bits[i] = 1'($urandom_range(0, 1));
      run_burst("back_to_back_12", 0, 12, 127);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'($urandom_range(0, 1)), 1'b1);
         @(negedge clk);
      end
      drive(0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check_idle("reset_mid_symbol", 0, 127);
      reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check_idle("after_reset_mid", 0, 127);
      end
      $display("test_reset_mid: done");
   endtask

   task automatic test_saturation();
      tx_bits[0] = 1'b0;
      run_burst("a128_bit0", 1, 1, 128);
      tx_bits[0] = 1'b1;
      run_burst("a128_bit1", 1, 1, 128);
   endtask

   initial begin
      test_reset();
      test_single();
      test_pattern();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
